// File: rtl/fb_scaler_reader.sv
// Frame-buffer read controller: maps the timing-generator coordinate to a downscaled BRAM address
// and realigns colour with delayed DE/syncs. Optional FB_TEST_PATTERN_EN adds a colour-bar source.
module fb_scaler_reader #(
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x_pixel,
  input  logic [9:0]          y_pixel,
  input  logic                DE,
  input  logic                h_sync,
  input  logic                v_sync,
`ifdef FB_TEST_PATTERN_EN
  input  logic                pattern_en,
`endif
  output logic                rclk,
  output logic                d_en,
  output logic [ADDR_W-1:0]   rAddr,
  input  logic [DATA_W-1:0]   rData,
  output logic [DATA_W/3-1:0] red_port,
  output logic [DATA_W/3-1:0] green_port,
  output logic [DATA_W/3-1:0] blue_port,
  output logic                DE_o,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                frame_start
);

  localparam int unsigned CW       = DATA_W / 3;
  localparam int unsigned BitAct   = 0;
  localparam int unsigned BitDe    = 1;
  localparam int unsigned BitHs    = 2;
  localparam int unsigned BitVs    = 3;
  localparam int unsigned BitFirst = 4;
`ifdef FB_TEST_PATTERN_EN
  localparam int unsigned BitPat   = 5;
  localparam int unsigned BarLsb   = 6;
  localparam int unsigned BarW     = H_ACT / 8;
  localparam int unsigned PW       = 9;
`else
  localparam int unsigned PW       = 5;
`endif

  logic              act;
  logic [PW-1:0]     stage_a_d, stage_a_q;
  logic [PW-1:0]     pipe_d [RD_LAT];
  logic [PW-1:0]     pipe_q [RD_LAT];
  logic [PW-1:0]     tail;
  logic              d_en_d, d_en_q;
  logic [ADDR_W-1:0] raddr_d, raddr_q;
  logic [DATA_W-1:0] colour_d, colour_q;
  logic              de_o_d, de_o_q;
  logic              hs_o_d, hs_o_q;
  logic              vs_o_d, vs_o_q;
  logic              fs_d, fs_q;

  // Stage A: qualify the coordinate and form the scaled linear address.
  always_comb begin
    act       = DE && (32'(x_pixel) < H_ACT) && (32'(y_pixel) < V_ACT);
    stage_a_d = '0;
    stage_a_d[BitAct]   = act;
    stage_a_d[BitDe]    = DE;
    stage_a_d[BitHs]    = h_sync;
    stage_a_d[BitVs]    = v_sync;
    stage_a_d[BitFirst] = act && (x_pixel == 10'd0) && (y_pixel == 10'd0);
    d_en_d    = act;
    raddr_d   = '0;
    if (act) begin
      raddr_d = ADDR_W'(32'(y_pixel >> SCALE_SHIFT) * (H_ACT >> SCALE_SHIFT)
                        + 32'(x_pixel >> SCALE_SHIFT));
    end
`ifdef FB_TEST_PATTERN_EN
    stage_a_d[BitPat]      = pattern_en;
    stage_a_d[BarLsb +: 3] = 3'(32'(x_pixel) / BarW);
    d_en_d                 = act && !pattern_en;
`endif
  end

  // Stage B: control bits ride alongside the BRAM read latency.
  always_comb begin
    pipe_d[0] = stage_a_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage C: blanking forces colour to zero so stale read data never leaks out.
  always_comb begin
    tail     = pipe_q[RD_LAT-1];
    colour_d = '0;
    if (tail[BitAct]) begin
      colour_d = rData;
`ifdef FB_TEST_PATTERN_EN
      if (tail[BitPat]) begin
        colour_d = {{CW{tail[BarLsb+2]}}, {CW{tail[BarLsb+1]}}, {CW{tail[BarLsb]}}};
      end
`endif
    end
    de_o_d = tail[BitDe];
    hs_o_d = tail[BitHs];
    vs_o_d = tail[BitVs];
    fs_d   = tail[BitFirst];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_a_q <= '0;
      d_en_q    <= 1'b0;
      raddr_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      colour_q  <= '0;
      de_o_q    <= 1'b0;
      hs_o_q    <= 1'b0;
      vs_o_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      stage_a_q <= stage_a_d;
      d_en_q    <= d_en_d;
      raddr_q   <= raddr_d;
      pipe_q    <= pipe_d;
      colour_q  <= colour_d;
      de_o_q    <= de_o_d;
      hs_o_q    <= hs_o_d;
      vs_o_q    <= vs_o_d;
      fs_q      <= fs_d;
    end
  end

  assign rclk        = clk;
  assign d_en        = d_en_q;
  assign rAddr       = raddr_q;
  assign red_port    = colour_q[3*CW-1:2*CW];
  assign green_port  = colour_q[2*CW-1:CW];
  assign blue_port   = colour_q[CW-1:0];
  assign DE_o        = de_o_q;
  assign h_sync_o    = hs_o_q;
  assign v_sync_o    = vs_o_q;
  assign frame_start = fs_q;

endmodule
